program_memory_responder: RTL and testbench

//  Responder end of the program-memory read interface used by the dual-issue fetch manager:

---
 rtl/pm_pkg.sv | 16 +
 rtl/pm_byte_assembler.sv | 75 +++++++
 rtl/program_memory_responder.sv | 114 +++++++++++
 tb/tb_program_memory_responder.sv | 370 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pm_pkg.sv
// Shared program-memory definitions: read FSM states, NOP encoding and the
// instruction/byte geometry agreed between the fetch manager, loader and responder.
package pm_pkg;

  localparam int PM_INSTRUCTION_WIDTH = 32;
  localparam int PM_BYTE_WIDTH        = 8;
  localparam int PM_BYTES_PER_WORD    = PM_INSTRUCTION_WIDTH / PM_BYTE_WIDTH;

  localparam logic [PM_INSTRUCTION_WIDTH-1:0] INSTR_NOP = '0;

  typedef enum logic {
    PM_RD_IDLE = 1'b0,
    PM_RD_BUSY = 1'b1
  } pm_rd_state_e;

endpackage

// File: rtl/pm_byte_assembler.sv
// Packs loader bytes little-endian into instruction words, raises a one-cycle
// commit pulse per word and walks the write pointer through program memory.
module pm_byte_assembler
  import pm_pkg::*;
#(
  parameter int INSTRUCTION_WIDTH   = PM_INSTRUCTION_WIDTH,
  parameter int PROGRAM_MEMORY_SIZE = 64,
  parameter int ADDR_WIDTH_PM       = $clog2(PROGRAM_MEMORY_SIZE),
  parameter int BYTE_WIDTH          = PM_BYTE_WIDTH
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [BYTE_WIDTH-1:0]        byte_data,
  input  logic                         byte_strobe,
  input  logic                         load_clear,
  output logic                         wr_idle,
  output logic                         word_valid,
  output logic [INSTRUCTION_WIDTH-1:0] word,
  output logic [ADDR_WIDTH_PM-1:0]     wr_ptr,
  output logic                         load_full
);

  localparam int BPW   = INSTRUCTION_WIDTH / BYTE_WIDTH;
  localparam int CNT_W = (BPW > 1) ? $clog2(BPW) : 1;
  localparam logic [CNT_W-1:0]         LAST_BYTE = CNT_W'(BPW - 1);
  localparam logic [ADDR_WIDTH_PM-1:0] LAST_ADDR = ADDR_WIDTH_PM'(PROGRAM_MEMORY_SIZE - 1);

  logic [CNT_W-1:0]             byte_cnt;
  logic [INSTRUCTION_WIDTH-1:0] pack;
  logic                         accept;

  // The loader is stalled for exactly the commit cycle.
  assign wr_idle = ~word_valid;
  assign accept  = byte_strobe & wr_idle & ~load_clear;
  assign word    = pack;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byte_cnt   <= '0;
      word_valid <= 1'b0;
      wr_ptr     <= '0;
      load_full  <= 1'b0;
    end else begin
      if (word_valid) begin
        word_valid <= 1'b0;
        if (wr_ptr == LAST_ADDR) begin
          wr_ptr    <= '0;
          load_full <= 1'b1;
        end else begin
          wr_ptr <= wr_ptr + 1'b1;
        end
      end
      // Clear wins over both a pending pointer advance and a same-cycle byte.
      if (load_clear) begin
        byte_cnt  <= '0;
        wr_ptr    <= '0;
        load_full <= 1'b0;
      end else if (accept) begin
        if (byte_cnt == LAST_BYTE) begin
          byte_cnt   <= '0;
          word_valid <= 1'b1;
        end else begin
          byte_cnt <= byte_cnt + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      pack[int'(byte_cnt)*BYTE_WIDTH +: BYTE_WIDTH] <= byte_data;
    end
  end

endmodule

// File: rtl/program_memory_responder.sv
// Program-memory responder: fixed-latency single-word reads for the fetch manager
// and byte-serial loading through pm_byte_assembler.
module program_memory_responder
  import pm_pkg::*;
#(
  parameter int INSTRUCTION_WIDTH   = PM_INSTRUCTION_WIDTH,
  parameter int PROGRAM_MEMORY_SIZE = 64,
  parameter int ADDR_WIDTH_PM       = $clog2(PROGRAM_MEMORY_SIZE),
  parameter int BYTE_WIDTH          = PM_BYTE_WIDTH,
  parameter int READ_LATENCY        = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [ADDR_WIDTH_PM-1:0]     addr_rd_pm,
  input  logic                         rd_ins_pm,
  output logic [INSTRUCTION_WIDTH-1:0] data_bus_rd_pm,
  output logic                         rd_idle_pm,
  input  logic [BYTE_WIDTH-1:0]        data_bus_wr_pm,
  input  logic                         wr_byte_pm,
  output logic                         wr_idle_pm,
  input  logic                         load_clear,
  output logic                         load_full
);

  localparam int LAT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
  localparam logic [LAT_W-1:0]       LAT_INIT = LAT_W'(READ_LATENCY - 1);
  localparam logic [ADDR_WIDTH_PM:0] SIZE_EXT = (ADDR_WIDTH_PM + 1)'(PROGRAM_MEMORY_SIZE);

  logic [INSTRUCTION_WIDTH-1:0] mem [PROGRAM_MEMORY_SIZE];
  pm_rd_state_e                 state, state_next;
  logic [LAT_W-1:0]             lat_cnt;
  logic [ADDR_WIDTH_PM-1:0]     rd_addr;
  logic                         rd_done;
  logic [INSTRUCTION_WIDTH-1:0] rd_word;

  logic                         commit;
  logic [INSTRUCTION_WIDTH-1:0] commit_word;
  logic [ADDR_WIDTH_PM-1:0]     wr_ptr;

  pm_byte_assembler #(
    .INSTRUCTION_WIDTH  (INSTRUCTION_WIDTH),
    .PROGRAM_MEMORY_SIZE(PROGRAM_MEMORY_SIZE),
    .ADDR_WIDTH_PM      (ADDR_WIDTH_PM),
    .BYTE_WIDTH         (BYTE_WIDTH)
  ) u_asm (
    .clk        (clk),
    .rst        (rst),
    .byte_data  (data_bus_wr_pm),
    .byte_strobe(wr_byte_pm),
    .load_clear (load_clear),
    .wr_idle    (wr_idle_pm),
    .word_valid (commit),
    .word       (commit_word),
    .wr_ptr     (wr_ptr),
    .load_full  (load_full)
  );

  // Memory is sampled at the completion edge, so a commit landing on that same
  // edge is not yet visible while one landing earlier in the read is.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < PROGRAM_MEMORY_SIZE; i++) begin
        mem[i] <= '0;
      end
    end else if (commit) begin
      mem[wr_ptr] <= commit_word;
    end
  end

  assign rd_done    = (state == PM_RD_BUSY) && (lat_cnt == '0);
  assign rd_idle_pm = (state == PM_RD_IDLE);

  always_comb begin
    rd_word = INSTRUCTION_WIDTH'(INSTR_NOP);
    if ({1'b0, rd_addr} < SIZE_EXT) begin
      rd_word = mem[rd_addr];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= PM_RD_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      PM_RD_IDLE: if (rd_ins_pm) state_next = PM_RD_BUSY;
      PM_RD_BUSY: if (rd_done)   state_next = PM_RD_IDLE;
      default:                   state_next = PM_RD_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lat_cnt        <= '0;
      rd_addr        <= '0;
      data_bus_rd_pm <= '0;
    end else if (state == PM_RD_IDLE) begin
      if (rd_ins_pm) begin
        rd_addr <= addr_rd_pm;
        lat_cnt <= LAT_INIT;
      end
    end else if (rd_done) begin
      data_bus_rd_pm <= rd_word;
    end else begin
      lat_cnt <= lat_cnt - 1'b1;
    end
  end

endmodule

// File: tb/tb_program_memory_responder.sv
// Scenario bench for program_memory_responder: a memory/loader model feeds an
// expected-read queue that is drained as each read completes.
module tb_program_memory_responder;

  localparam int IW  = 32;
  localparam int PMS = 64;
  localparam int AW  = 6;
  localparam int BW  = 8;
  localparam int RL  = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [AW-1:0] addr_rd_pm = '0;
  logic          rd_ins_pm = 1'b0;
  logic [IW-1:0] data_bus_rd_pm;
  logic          rd_idle_pm;
  logic [BW-1:0] data_bus_wr_pm = '0;
  logic          wr_byte_pm = 1'b0;
  logic          wr_idle_pm;
  logic          load_clear = 1'b0;
  logic          load_full;

  program_memory_responder #(
    .INSTRUCTION_WIDTH  (IW),
    .PROGRAM_MEMORY_SIZE(PMS),
    .ADDR_WIDTH_PM      (AW),
    .BYTE_WIDTH         (BW),
    .READ_LATENCY       (RL)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .addr_rd_pm    (addr_rd_pm),
    .rd_ins_pm     (rd_ins_pm),
    .data_bus_rd_pm(data_bus_rd_pm),
    .rd_idle_pm    (rd_idle_pm),
    .data_bus_wr_pm(data_bus_wr_pm),
    .wr_byte_pm    (wr_byte_pm),
    .wr_idle_pm    (wr_idle_pm),
    .load_clear    (load_clear),
    .load_full     (load_full)
  );

  always #5 clk = ~clk;

  int            tests = 0;
  int            fails = 0;
  logic [IW-1:0] model_mem [PMS];
  int            model_ptr;
  int            model_cnt;
  logic          model_full;
  logic [IW-1:0] model_word;
  logic [IW-1:0] exp_q [$];

  function automatic logic [IW-1:0] pattern(input int w);
    logic [7:0] b;
    b = 8'(w);
    return {b ^ 8'hA5, b, 8'h5A, ~b};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < PMS; i++) model_mem[i] = '0;
    model_ptr = 0; model_cnt = 0; model_full = 1'b0; model_word = '0;
  endtask

  task automatic model_byte(input logic [7:0] b);
    model_word[model_cnt*BW +: BW] = b;
    model_cnt++;
    if (model_cnt == IW / BW) begin
      model_mem[model_ptr] = model_word;
      model_cnt = 0;
      if (model_ptr == PMS - 1) begin
        model_ptr  = 0;
        model_full = 1'b1;
      end else begin
        model_ptr++;
      end
    end
  endtask

  task automatic send_byte(input logic [7:0] b, output logic idle_after);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!wr_idle_pm && guard < 16) begin
      @(negedge clk);
      guard++;
    end
    data_bus_wr_pm = b;
    wr_byte_pm     = 1'b1;
    @(negedge clk);
    wr_byte_pm = 1'b0;
    idle_after = wr_idle_pm;
    model_byte(b);
  endtask

  task automatic send_word(input logic [IW-1:0] w);
    logic dummy;
    for (int k = 0; k < IW / BW; k++) send_byte(w[k*BW +: BW], dummy);
  endtask

  task automatic pulse_clear();
    @(negedge clk);
    load_clear = 1'b1;
    @(negedge clk);
    load_clear = 1'b0;
    model_ptr = 0; model_cnt = 0; model_full = 1'b0;
  endtask

  task automatic do_read(input logic [AW-1:0] a, output logic [IW-1:0] d, output int busy);
    @(negedge clk);
    addr_rd_pm = a;
    rd_ins_pm  = 1'b1;
    @(negedge clk);
    rd_ins_pm = 1'b0;
    busy = 0;
    while (!rd_idle_pm && busy < 20) begin
      busy++;
      @(negedge clk);
    end
    d = data_bus_rd_pm;
  endtask

  task automatic read_and_check(input logic [AW-1:0] a, input string name);
    logic [IW-1:0] d;
    logic [IW-1:0] e;
    int            busy;
    exp_q.push_back(model_mem[a]);
    do_read(a, d, busy);
    e = exp_q.pop_front();
    tests++;
    if (d !== e) begin
      fails++;
      $display("FAIL %s data: got %h expected %h", name, d, e);
    end
    tests++;
    if (busy != RL) begin
      fails++;
      $display("FAIL %s latency: got %0d expected %0d", name, busy, RL);
    end
  endtask

  task automatic test_reset();
    model_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    tests++;
    if (rd_idle_pm !== 1'b1 || wr_idle_pm !== 1'b1 || load_full !== 1'b0) begin
      fails++;
      $display("FAIL reset_flags: got rd_idle=%b wr_idle=%b full=%b expected 1 1 0",
               rd_idle_pm, wr_idle_pm, load_full);
    end
    tests++;
    if (data_bus_rd_pm !== '0) begin
      fails++;
      $display("FAIL reset_data: got %h expected 0", data_bus_rd_pm);
    end
    rst = 1'b0;
    read_and_check(6'd3, "reset_mem3");
  endtask

  task automatic test_load_first();
    logic ia;
    send_byte(8'h13, ia);
    send_byte(8'h00, ia);
    send_byte(8'h00, ia);
    tests++;
    if (ia !== 1'b1) begin
      fails++;
      $display("FAIL load_idle_mid: got %b expected 1", ia);
    end
    send_byte(8'h00, ia);
    tests++;
    if (ia !== 1'b0) begin
      fails++;
      $display("FAIL load_idle_commit: got %b expected 0", ia);
    end
    @(negedge clk);
    tests++;
    if (wr_idle_pm !== 1'b1) begin
      fails++;
      $display("FAIL load_idle_after: got %b expected 1", wr_idle_pm);
    end
    send_word(32'hDEADBEEF);
  endtask

  task automatic test_read();
    logic [IW-1:0] held;
    read_and_check(6'd0, "read0");
    read_and_check(6'd1, "read1_ptr");
    held = model_mem[1];
    send_word(32'hCAFEF00D);
    repeat (2) @(negedge clk);
    tests++;
    if (data_bus_rd_pm !== held) begin
      fails++;
      $display("FAIL read_hold: got %h expected %h", data_bus_rd_pm, held);
    end
    read_and_check(6'd2, "read2");
  endtask

  task automatic test_back_to_back();
    logic [IW-1:0] e;
    exp_q.push_back(model_mem[0]);
    exp_q.push_back(model_mem[1]);
    @(negedge clk);
    addr_rd_pm = 6'd0;
    rd_ins_pm  = 1'b1;
    @(negedge clk);
    addr_rd_pm = 6'd1;
    tests++;
    if (rd_idle_pm !== 1'b0) begin
      fails++;
      $display("FAIL b2b_busy1: got %b expected 0", rd_idle_pm);
    end
    @(negedge clk);
    @(negedge clk);
    e = exp_q.pop_front();
    tests++;
    if (rd_idle_pm !== 1'b1 || data_bus_rd_pm !== e) begin
      fails++;
      $display("FAIL b2b_first: got idle=%b data=%h expected idle=1 data=%h", rd_idle_pm, data_bus_rd_pm, e);
    end
    @(negedge clk);
    tests++;
    if (rd_idle_pm !== 1'b0) begin
      fails++;
      $display("FAIL b2b_busy2: got %b expected 0", rd_idle_pm);
    end
    @(negedge clk);
    @(negedge clk);
    rd_ins_pm = 1'b0;
    e = exp_q.pop_front();
    tests++;
    if (rd_idle_pm !== 1'b1 || data_bus_rd_pm !== e) begin
      fails++;
      $display("FAIL b2b_second: got idle=%b data=%h expected idle=1 data=%h", rd_idle_pm, data_bus_rd_pm, e);
    end
    @(negedge clk);
  endtask

  task automatic test_wrap();
    logic ia;
    logic [IW-1:0] w;
    pulse_clear();
    tests++;
    if (load_full !== 1'b0) begin
      fails++;
      $display("FAIL wrap_cleared: got %b expected 0", load_full);
    end
    for (int i = 0; i < PMS - 1; i++) send_word(pattern(i));
    tests++;
    if (load_full !== 1'b0) begin
      fails++;
      $display("FAIL wrap_early: got %b expected 0", load_full);
    end
    w = pattern(PMS - 1);
    for (int k = 0; k < IW / BW; k++) send_byte(w[k*BW +: BW], ia);
    @(negedge clk);
    tests++;
    if (load_full !== 1'b1) begin
      fails++;
      $display("FAIL wrap_full: got %b expected 1", load_full);
    end
    send_word(32'h11223344);
    tests++;
    if (load_full !== 1'b1) begin
      fails++;
      $display("FAIL wrap_sticky: got %b expected 1", load_full);
    end
    read_and_check(6'd0, "wrap_mem0");
    read_and_check(6'd63, "wrap_mem63");
    read_and_check(6'd1, "wrap_mem1");
  endtask

  task automatic test_collision();
    logic ia;
    logic [IW-1:0] w;
    logic [IW-1:0] e;
    pulse_clear();
    for (int i = 0; i < 5; i++) send_word(32'h50000000 + i);
    w = 32'h0BADC0DE;
    for (int k = 0; k < 3; k++) send_byte(w[k*BW +: BW], ia);
    @(negedge clk);
    exp_q.push_back(model_mem[5]);
    addr_rd_pm = 6'd5;
    rd_ins_pm  = 1'b1;
    @(negedge clk);
    rd_ins_pm      = 1'b0;
    data_bus_wr_pm = w[3*BW +: BW];
    wr_byte_pm     = 1'b1;
    @(negedge clk);
    wr_byte_pm = 1'b0;
    model_byte(w[3*BW +: BW]);
    tests++;
    if (wr_idle_pm !== 1'b0 || rd_idle_pm !== 1'b0) begin
      fails++;
      $display("FAIL coll_align: got wr_idle=%b rd_idle=%b expected 0 0", wr_idle_pm, rd_idle_pm);
    end
    @(negedge clk);
    e = exp_q.pop_front();
    tests++;
    if (rd_idle_pm !== 1'b1 || data_bus_rd_pm !== e) begin
      fails++;
      $display("FAIL coll_old: got idle=%b data=%h expected idle=1 data=%h", rd_idle_pm, data_bus_rd_pm, e);
    end
    read_and_check(6'd5, "coll_new");
  endtask

  task automatic test_reset_midflight();
    logic ia;
    send_byte(8'h77, ia);
    send_byte(8'h66, ia);
    @(negedge clk);
    addr_rd_pm = 6'd1;
    rd_ins_pm  = 1'b1;
    @(negedge clk);
    rd_ins_pm = 1'b0;
    tests++;
    if (rd_idle_pm !== 1'b0) begin
      fails++;
      $display("FAIL rst_busy: got %b expected 0", rd_idle_pm);
    end
    rst = 1'b1;
    #1;
    tests++;
    if (rd_idle_pm !== 1'b1 || wr_idle_pm !== 1'b1 || data_bus_rd_pm !== '0) begin
      fails++;
      $display("FAIL rst_abort: got rd_idle=%b wr_idle=%b data=%h expected 1 1 0",
               rd_idle_pm, wr_idle_pm, data_bus_rd_pm);
    end
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    send_word(32'hA1B2C3D4);
    read_and_check(6'd0, "rst_load0");
    read_and_check(6'd5, "rst_mem5");
    send_byte(8'hEE, ia);
    send_byte(8'hFF, ia);
    @(negedge clk);
    load_clear     = 1'b1;
    wr_byte_pm     = 1'b1;
    data_bus_wr_pm = 8'hAA;
    @(negedge clk);
    load_clear = 1'b0;
    wr_byte_pm = 1'b0;
    model_ptr = 0; model_cnt = 0; model_full = 1'b0;
    send_word(32'h04030201);
    read_and_check(6'd0, "clr_mem0");
    read_and_check(6'd1, "clr_mem1");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_load_first();
    test_read();
    test_back_to_back();
    test_wrap();
    test_collision();
    test_reset_midflight();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
